// File: rtl/ar_request_fifo.sv
// In-order AR request buffer: circular FIFO of arbitrary DEPTH with level, almost_full and flush.
// Define AR_REQUEST_FIFO_BYPASS_EN to let requests pass straight through an empty FIFO.
module ar_request_fifo #(
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned SIZE_WIDTH  = 3,
  parameter int unsigned BURST_WIDTH = 2,
  parameter int unsigned QOS_WIDTH   = 4,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AF_THRESH   = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ID_WIDTH-1:0]          in_id,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic [LEN_WIDTH-1:0]         in_len,
  input  logic [SIZE_WIDTH-1:0]        in_size,
  input  logic [BURST_WIDTH-1:0]       in_burst,
  input  logic [QOS_WIDTH-1:0]         in_qos,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ID_WIDTH-1:0]          out_id,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [LEN_WIDTH-1:0]         out_len,
  output logic [SIZE_WIDTH-1:0]        out_size,
  output logic [BURST_WIDTH-1:0]       out_burst,
  output logic [QOS_WIDTH-1:0]         out_qos,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
  output logic                         empty
);

  localparam int unsigned ENT_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH
                                + BURST_WIDTH + QOS_WIDTH;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] in_ent, head;
  logic             full, stored_valid, push, pop;

  assign in_ent       = {in_id, in_addr, in_len, in_size, in_burst, in_qos};
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign level        = count;
  assign almost_full  = (count >= AF_C);
  assign in_ready     = ~full & ~flush;
  assign stored_valid = ~empty & ~flush;
  assign pop          = stored_valid & out_ready;

`ifdef AR_REQUEST_FIFO_BYPASS_EN
  logic bypass;
  // A bypassed request that is consumed immediately never occupies a slot.
  assign bypass    = empty & ~flush & in_valid;
  assign out_valid = stored_valid | bypass;
  assign head      = bypass ? in_ent : mem[rd_ptr];
  assign push      = in_valid & in_ready & ~(bypass & out_ready);
`else
  assign out_valid = stored_valid;
  assign head      = mem[rd_ptr];
  assign push      = in_valid & in_ready;
`endif

  assign {out_id, out_addr, out_len, out_size, out_burst, out_qos} = head;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);

endmodule

// File: tb/tb_ar_request_fifo.sv
// Randomized and directed checks of ar_request_fifo (DEPTH=8 and DEPTH=5) against a queue model.
module tb_ar_request_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: DEPTH=8, AF_THRESH=6. Index 1: DEPTH=5, default AF_THRESH.
  logic [1:0]       flush, in_valid, out_ready, in_ready, out_valid, almost_full, empty;
  logic [1:0][52:0] in_ent, out_ent;
  logic [3:0]       lvl8;
  logic [2:0]       lvl5;

  int checks = 0;
  int failures = 0;
  bit [52:0] q0[$];
  bit [52:0] q1[$];

  ar_request_fifo #(.DEPTH(8), .AF_THRESH(6)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_id(in_ent[0][52:49]), .in_addr(in_ent[0][48:17]), .in_len(in_ent[0][16:9]),
    .in_size(in_ent[0][8:6]), .in_burst(in_ent[0][5:4]), .in_qos(in_ent[0][3:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_id(out_ent[0][52:49]), .out_addr(out_ent[0][48:17]), .out_len(out_ent[0][16:9]),
    .out_size(out_ent[0][8:6]), .out_burst(out_ent[0][5:4]), .out_qos(out_ent[0][3:0]),
    .level(lvl8), .almost_full(almost_full[0]), .empty(empty[0])
  );

  ar_request_fifo #(.DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_id(in_ent[1][52:49]), .in_addr(in_ent[1][48:17]), .in_len(in_ent[1][16:9]),
    .in_size(in_ent[1][8:6]), .in_burst(in_ent[1][5:4]), .in_qos(in_ent[1][3:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_id(out_ent[1][52:49]), .out_addr(out_ent[1][48:17]), .out_len(out_ent[1][16:9]),
    .out_size(out_ent[1][8:6]), .out_burst(out_ent[1][5:4]), .out_qos(out_ent[1][3:0]),
    .level(lvl5), .almost_full(almost_full[1]), .empty(empty[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int mdepth(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  function automatic int maf(input int k);
    return (k == 0) ? 6 : 3;
  endfunction

  function automatic int msize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit [52:0] mhead(input int k);
    if (k == 0) return (q0.size() > 0) ? q0[0] : '0;
    return (q1.size() > 0) ? q1[0] : '0;
  endfunction

  function automatic bit [52:0] rnd_ent();
    bit [63:0] t;
    t = {$urandom, $urandom};
    return t[52:0];
  endfunction

  function automatic bit [52:0] seq_ent(input int i);
    bit [52:0] e;
    e = rnd_ent();
    e[52:49] = 4'(i);
    e[48:17] = 32'(i * 16 + 3);
    return e;
  endfunction

  // Check every output of both DUTs against the model, then advance one clock.
  task automatic tick();
    bit [1:0] do_push, do_pop;
    #2;
    for (int k = 0; k < 2; k++) begin
      int        sz;
      bit        exp_ir, exp_ov, byp;
      bit [52:0] exp_ent;
      logic [3:0] lvl;
      sz      = msize(k);
      exp_ir  = (sz < mdepth(k)) && !flush[k];
      exp_ov  = (sz > 0) && !flush[k];
      exp_ent = mhead(k);
      byp     = 1'b0;
`ifdef AR_REQUEST_FIFO_BYPASS_EN
      if (sz == 0 && !flush[k] && in_valid[k]) begin
        byp = 1'b1; exp_ov = 1'b1; exp_ent = in_ent[k];
      end
`endif
      lvl = (k == 0) ? lvl8 : {1'b0, lvl5};
      check($sformatf("in_ready%0d", k), 64'(in_ready[k]), 64'(exp_ir));
      check($sformatf("out_valid%0d", k), 64'(out_valid[k]), 64'(exp_ov));
      check($sformatf("level%0d", k), 64'(lvl), 64'(sz));
      check($sformatf("empty%0d", k), 64'(empty[k]), 64'(sz == 0));
      check($sformatf("almost_full%0d", k), 64'(almost_full[k]), 64'(sz >= maf(k)));
      if (exp_ov) check($sformatf("out_ent%0d", k), 64'(out_ent[k]), 64'(exp_ent));
      do_push[k] = in_valid[k] && exp_ir && !(byp && out_ready[k]);
      do_pop[k]  = (sz > 0) && !flush[k] && out_ready[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush[k]) begin
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        if (do_pop[k])  begin if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front()); end
        if (do_push[k]) begin if (k == 0) q0.push_back(in_ent[k]); else q1.push_back(in_ent[k]); end
      end
    end
    #1;
  endtask

  initial begin
    flush = '0; in_valid = '0; out_ready = '0; in_ent = '0;
    #3;
    tick();
    rst_n = 1'b1;
    tick();

    // Fill DEPTH=8 with ids 0..7, then a 9th request that must be refused.
    for (int i = 0; i < 9; i++) begin
      in_valid[0] = 1'b1; in_ent[0] = seq_ent(i);
      tick();
    end
    check("full_level", 64'(lvl8), 64'd8);
    check("full_in_ready", 64'(in_ready[0]), 64'd0);

    // Drain in order.
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_id", 64'(out_ent[0][52:49]), 64'(i));
      tick();
    end
    check("drained_empty", 64'(empty[0]), 64'd1);
    check("drained_out_valid", 64'(out_valid[0]), 64'd0);
    out_ready[0] = 1'b0;

    // Continuous stream through DEPTH=5 exercises pointer wrap.
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_ent[1] = seq_ent(i);
      tick();
    end
    in_valid[1] = 1'b0;
    tick();
    tick();
    out_ready[1] = 1'b0;

    // Flush with in_valid held high.
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_ent[0] = seq_ent(i);
      tick();
    end
    flush[0] = 1'b1; in_ent[0] = seq_ent(9);
    tick();
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    tick();
    check("post_flush_level", 64'(lvl8), 64'd0);

    // Asynchronous reset between clock edges.
    in_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_ent[0] = seq_ent(i);
      tick();
    end
    in_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", 64'(lvl8), 64'd0);
    check("async_rst_out_valid", 64'(out_valid[0]), 64'd0);
    q0.delete(); q1.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = (c < 300) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
        out_ready[k] = (c < 300) ? ($urandom_range(2) == 0) : ($urandom_range(3) != 0);
        flush[k]     = ($urandom_range(49) == 0);
        in_ent[k]    = rnd_ent();
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
